wb_port_arb: RTL and testbench
==============================

# wb_port_arb

Writeback-port arbiter for the single regfile write port. It sits between the mem/wb pipeline register and the regfile, and shares the port between the in-order pipeline result and results from a long-latency unit (mul/div). Long-latency results are held in a small buffer until the port is free. A starvation counter briefly stalls writeback so buffered results cannot wait forever. Busy lookups on the buffer give decode the RAW hazard information it needs.

## Interface
Parameters:
- DEPTH, 2, long-latency result buffer entries (power of 2, ≥2)
- STARVE_MAX, 4, cycles a non-empty buffer may go ungranted before wb_stall_req fires (≥1)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- pipe_wr_reg  in  1  pipeline result wants to write
- pipe_wr_regindex  in  5  pipeline destination
- pipe_wr_wdata  in  32  pipeline data
- pipe_rd_is_x1  in  1  pipeline rd is x1
- pipe_rd_is_xn  in  1  pipeline rd is non-zero, non-x1
- pipe_exporint  in  1  exception/interrupt at wb; kills the pipeline write
- ll_valid  in  1  long-latency result offered
- ll_ready  out  1  buffer can accept
- ll_regindex  in  5  long-latency destination
- ll_wdata  in  32  long-latency data
- wb_stall_req  out  1  hold mem/wb one cycle; pipeline write replays next cycle
- chk_rs1idx, chk_rs2idx  in  5 each  decode source indices
- chk_rs1_busy, chk_rs2_busy  out  1 each  index ≠0 and matches a valid buffer entry
- wb2regfile_wr_reg  out  1  regfile write enable
- wb2regfile_wr_regindex  out  5  regfile index
- wb2regfile_wr_wdata  out  32  regfile data
- wb2regfile_rd_is_x1  out  1  rd is x1
- wb2regfile_rd_is_xn  out  1  rd is non-zero, non-x1

## Operation
- Accept: the handshake completes when ll_valid & ll_ready. The entry is pushed at the buffer tail. ll_ready is ~full, from registered count only; there is no full-and-pop pass-through.
- An accepted ll_regindex==0 is consumed and dropped: no entry, no write.
- pipe_act = pipe_wr_reg & ~pipe_exporint & ~wb_stall_req.
- Grant priority:
  1. wb_stall_req=1 with the buffer non-empty: the head writes and is popped.
  2. Otherwise pipe_act: the pipeline writes.
  3. Otherwise buffer non-empty: the head writes and is popped.
  4. Otherwise wb2regfile_wr_reg=0.
- Outputs for a pipeline grant pass through pipe_rd_is_x1/xn. For a buffer grant, rd_is_x1=(idx==1) and rd_is_xn=(idx>1).
- When idle, the index, data and flag outputs show the pipeline inputs.
- WAW: a pipeline grant whose index (≠0) matches valid buffer entries invalidates those entries in the same edge. The pipeline write is younger. Invalidated entries are skipped at pop with no write.
  - pipe_exporint or stall suppresses this invalidation.
  - WAW against a result still inside the long-latency unit is decode's responsibility.
- Starvation counter starve_cnt:
  - Increments each cycle the buffer holds a valid head that is not granted.
  - Clears on any pop and when the buffer is empty.
  - wb_stall_req = (starve_cnt == STARVE_MAX), driven from the register.
- Busy lookup is combinational over valid entries, and includes an entry being pushed this cycle. Popped or invalidated entries read not-busy from the next cycle.

## Timing
- Reset values: buffer empty and all valid bits 0, starve_cnt=0, ll_ready=1 from the cycle after rst.
- While rst=1: ll_ready=0, wr_reg=0, wb_stall_req=0, busy=0.
- A reset mid-operation discards buffered results.
- Pipeline path latency is 0 (combinational).
- Long-latency path: earliest regfile write is the cycle after acceptance. There is no bypass.
- Under continuous pipeline writes, wb_stall_req rises STARVE_MAX cycles after the entry becomes head and lasts exactly 1 cycle per pop.
- Pointers wrap modulo DEPTH.
- Push and pop in the same cycle keep the count unchanged.

## Structure
- Shared package wb_pkg holds:
  - wb_req_t {idx[4:0], data[31:0]}
  - REG_X0=5'd0 and REG_X1=5'd1
  - the rd_is_x1/xn derivation function
- Sub-module wb_ll_fifo: DEPTH-entry circular buffer with per-entry valid, index-match invalidate, two CAM lookup ports, and skip-invalid pop.
- The top level holds the arbitration and starve_cnt.

## Test plan
- Idle pipeline; push idx 5 data 32'hDEADBEEF → the next cycle wr_reg=1, idx=5, data=DEADBEEF, rd_is_xn=1; chk busy(5)=1 only during the buffered cycle.
- Pipeline writes every cycle; push idx 7 → wb_stall_req=1 for exactly 1 cycle after 4 cycles as head; regfile gets idx 7 that cycle; the held pipeline write lands the next cycle.
- Pipeline busy; push idx 3 and idx 4 → ll_ready=0 and the third offer is held; after one pop ll_ready=1; writes occur in order 3, 4.
- Buffer holds idx 9 = 32'h11; pipeline writes idx 9 = 32'h22 → the entry is dropped, final x9=22, busy(9)=0 the next cycle. Repeating with pipe_exporint=1 keeps the entry, and it writes 11.
- pipe_exporint=1, pipe_wr_reg=1, buffer empty → wr_reg=0; with the buffer non-empty, the head is granted.
- Push idx 0 → accepted with no write and no busy. Assert rst with 2 entries queued → no writes afterwards, and ll_ready=1 after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback-port arbiter: request payload,
// architectural register constants and the rd_is_x1/rd_is_xn derivation.
package wb_pkg;

  localparam logic [4:0] REG_X0 = 5'd0;
  localparam logic [4:0] REG_X1 = 5'd1;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } wb_req_t;

  typedef struct packed {
    logic is_x1;
    logic is_xn;
  } rd_flags_t;

  function automatic rd_flags_t rd_flags(input logic [4:0] idx);
    rd_flags_t f;
    f.is_x1 = (idx == REG_X1);
    f.is_xn = (idx > REG_X1);
    return f;
  endfunction

endpackage

// File: rtl/wb_ll_fifo.sv
// Circular buffer for long-latency results with per-entry valid bits,
// index-match invalidation, two busy lookup ports and skip-invalid pop.
module wb_ll_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  wb_req_t    push_req,
  input  logic       pop,
  input  logic       inv_en,
  input  logic [4:0] inv_idx,
  input  logic [4:0] chk_a_idx,
  input  logic [4:0] chk_b_idx,
  output logic       chk_a_busy,
  output logic       chk_b_busy,
  output logic       full,
  output logic       head_valid,
  output wb_req_t    head_req
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_req_t          mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             found;
  logic [AW-1:0]    sel_ptr;
  logic [CW-1:0]    drop_n;
  logic             do_drop;

  // Oldest valid entry wins; descending scan lets the lowest offset overwrite.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    found   = 1'b0;
    sel_ptr = head_q;
    drop_n  = count_q;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (CW'(i) < count_q && valid_q[head_q + AW'(i)]) begin
        found   = 1'b1;
        sel_ptr = head_q + AW'(i);
        drop_n  = CW'(i + 1);
      end
    end
  end

  assign head_valid = found;
  assign head_req   = mem_q[sel_ptr];
  assign full       = (count_q == CW'(DEPTH));
  // With no valid entry left, every occupied slot is stale and drains at once.
  assign do_drop    = (pop & found) | ~found;

  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (inv_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && mem_q[i].idx == inv_idx) valid_d[i] = 1'b0;
      end
    end
    if (pop && found) valid_d[sel_ptr] = 1'b0;
    if (do_drop) begin
      head_d  = head_q + AW'(drop_n);
      count_d = count_q - drop_n;
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + AW'(1);
      count_d         = count_d + CW'(1);
    end
  end

  always_comb begin
    chk_a_busy = 1'b0;
    chk_b_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && mem_q[i].idx == chk_a_idx) chk_a_busy = 1'b1;
      if (valid_q[i] && mem_q[i].idx == chk_b_idx) chk_b_busy = 1'b1;
    end
    if (push && push_req.idx == chk_a_idx) chk_a_busy = 1'b1;
    if (push && push_req.idx == chk_b_idx) chk_b_busy = 1'b1;
    if (chk_a_idx == REG_X0) chk_a_busy = 1'b0;
    if (chk_b_idx == REG_X0) chk_b_busy = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: payload storage is not reset; the valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= push_req;
  end

endmodule

// File: rtl/wb_port_arb.sv
// Regfile write-port arbiter: pipeline results versus buffered long-latency
// results, with a starvation counter that forces a one-cycle writeback stall.
module wb_port_arb
  import wb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wr_reg,
  input  logic [4:0]  pipe_wr_regindex,
  input  logic [31:0] pipe_wr_wdata,
  input  logic        pipe_rd_is_x1,
  input  logic        pipe_rd_is_xn,
  input  logic        pipe_exporint,
  input  logic        ll_valid,
  output logic        ll_ready,
  input  logic [4:0]  ll_regindex,
  input  logic [31:0] ll_wdata,
  output logic        wb_stall_req,
  input  logic [4:0]  chk_rs1idx,
  input  logic [4:0]  chk_rs2idx,
  output logic        chk_rs1_busy,
  output logic        chk_rs2_busy,
  output logic        wb2regfile_wr_reg,
  output logic [4:0]  wb2regfile_wr_regindex,
  output logic [31:0] wb2regfile_wr_wdata,
  output logic        wb2regfile_rd_is_x1,
  output logic        wb2regfile_rd_is_xn
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_q, starve_d;
  logic          full, head_valid, push, pipe_act, grant_buf, busy_a, busy_b;
  wb_req_t       head_req;
  rd_flags_t     head_flags;

  assign ll_ready     = ~rst & ~full;
  assign push         = ll_valid & ll_ready & (ll_regindex != REG_X0);
  assign wb_stall_req = ~rst & (starve_q == SW'(STARVE_MAX));
  assign pipe_act     = ~rst & pipe_wr_reg & ~pipe_exporint & ~wb_stall_req;
  assign grant_buf    = ~rst & head_valid & (wb_stall_req | ~pipe_act);
  assign chk_rs1_busy = ~rst & busy_a;
  assign chk_rs2_busy = ~rst & busy_b;
  assign head_flags   = rd_flags(head_req.idx);

  wb_ll_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_req   ('{idx: ll_regindex, data: ll_wdata}),
    .pop        (grant_buf),
    .inv_en     (pipe_act & (pipe_wr_regindex != REG_X0)),
    .inv_idx    (pipe_wr_regindex),
    .chk_a_idx  (chk_rs1idx),
    .chk_b_idx  (chk_rs2idx),
    .chk_a_busy (busy_a),
    .chk_b_busy (busy_b),
    .full       (full),
    .head_valid (head_valid),
    .head_req   (head_req)
  );

  // Idle and pipeline grants both present the pipeline inputs.
  always_comb begin
    wb2regfile_wr_reg      = pipe_act | grant_buf;
    wb2regfile_wr_regindex = pipe_wr_regindex;
    wb2regfile_wr_wdata    = pipe_wr_wdata;
    wb2regfile_rd_is_x1    = pipe_rd_is_x1;
    wb2regfile_rd_is_xn    = pipe_rd_is_xn;
    if (grant_buf) begin
      wb2regfile_wr_regindex = head_req.idx;
      wb2regfile_wr_wdata    = head_req.data;
      wb2regfile_rd_is_x1    = head_flags.is_x1;
      wb2regfile_rd_is_xn    = head_flags.is_xn;
    end
  end

  always_comb begin
    starve_d = '0;
    if (head_valid && !grant_buf) starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

endmodule

// File: tb/tb_wb_port_arb.sv
// Self-checking bench for wb_port_arb: directed scenarios followed by random
// traffic, all compared every cycle against a queue-based reference model.
module tb_wb_port_arb;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wr_reg, pipe_rd_is_x1, pipe_rd_is_xn, pipe_exporint;
  logic [4:0]  pipe_wr_regindex, ll_regindex, chk_rs1idx, chk_rs2idx;
  logic [31:0] pipe_wr_wdata, ll_wdata;
  logic        ll_valid, ll_ready, wb_stall_req, chk_rs1_busy, chk_rs2_busy;
  logic        wb2regfile_wr_reg, wb2regfile_rd_is_x1, wb2regfile_rd_is_xn;
  logic [4:0]  wb2regfile_wr_regindex;
  logic [31:0] wb2regfile_wr_wdata;

  wb_port_arb #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .pipe_wr_reg(pipe_wr_reg), .pipe_wr_regindex(pipe_wr_regindex),
    .pipe_wr_wdata(pipe_wr_wdata), .pipe_rd_is_x1(pipe_rd_is_x1),
    .pipe_rd_is_xn(pipe_rd_is_xn), .pipe_exporint(pipe_exporint),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_regindex(ll_regindex),
    .ll_wdata(ll_wdata), .wb_stall_req(wb_stall_req),
    .chk_rs1idx(chk_rs1idx), .chk_rs2idx(chk_rs2idx),
    .chk_rs1_busy(chk_rs1_busy), .chk_rs2_busy(chk_rs2_busy),
    .wb2regfile_wr_reg(wb2regfile_wr_reg),
    .wb2regfile_wr_regindex(wb2regfile_wr_regindex),
    .wb2regfile_wr_wdata(wb2regfile_wr_wdata),
    .wb2regfile_rd_is_x1(wb2regfile_rd_is_x1),
    .wb2regfile_rd_is_xn(wb2regfile_rd_is_xn)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    bit          vld;
  } ent_t;

  ent_t q[$];
  int   starve = 0;
  int   errors = 0;
  int   checks = 0;
  int   m_h;
  bit   m_gbuf, m_pact, m_push;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int first_valid();
    for (int i = 0; i < q.size(); i++) if (q[i].vld) return i;
    return -1;
  endfunction

  function automatic bit exp_busy(input logic [4:0] r);
    if (rst || r == 5'd0) return 1'b0;
    if (m_push && ll_regindex == r) return 1'b1;
    for (int i = 0; i < q.size(); i++) if (q[i].vld && q[i].idx == r) return 1'b1;
    return 1'b0;
  endfunction

  // Settle the current inputs and compare every output with the model.
  task automatic eval();
    bit exp_stall, exp_ready;
    #2;
    m_h       = first_valid();
    exp_stall = !rst && starve == STARVE_MAX;
    exp_ready = !rst && q.size() < DEPTH;
    m_pact    = !rst && pipe_wr_reg && !pipe_exporint && !exp_stall;
    m_gbuf    = !rst && m_h >= 0 && (exp_stall || !m_pact);
    m_push    = ll_valid && exp_ready && ll_regindex != 5'd0;
    check("ll_ready", ll_ready, exp_ready);
    check("stall", wb_stall_req, exp_stall);
    check("wr_reg", wb2regfile_wr_reg, m_pact || m_gbuf);
    check("busy1", chk_rs1_busy, exp_busy(chk_rs1idx));
    check("busy2", chk_rs2_busy, exp_busy(chk_rs2idx));
    if (!rst) begin
      if (m_gbuf) begin
        check("buf_idx", wb2regfile_wr_regindex, q[m_h].idx);
        check("buf_data", wb2regfile_wr_wdata, q[m_h].data);
        check("buf_x1", wb2regfile_rd_is_x1, q[m_h].idx == 5'd1);
        check("buf_xn", wb2regfile_rd_is_xn, q[m_h].idx > 5'd1);
      end else begin
        check("pipe_idx", wb2regfile_wr_regindex, pipe_wr_regindex);
        check("pipe_data", wb2regfile_wr_wdata, pipe_wr_wdata);
        check("pipe_x1", wb2regfile_rd_is_x1, pipe_rd_is_x1);
        check("pipe_xn", wb2regfile_rd_is_xn, pipe_rd_is_xn);
      end
    end
  endtask

  // Clock edge and model state update from the decisions made in eval().
  task automatic tick();
    int nxt;
    @(posedge clk);
    if (rst) begin
      q.delete();
      starve = 0;
    end else begin
      nxt = (m_h >= 0 && !m_gbuf) ? starve + 1 : 0;
      if (m_pact && pipe_wr_regindex != 5'd0)
        for (int i = 0; i < q.size(); i++) if (q[i].idx == pipe_wr_regindex) q[i].vld = 1'b0;
      if (m_gbuf) for (int k = 0; k <= m_h; k++) void'(q.pop_front());
      else if (m_h < 0) q.delete();
      if (m_push) q.push_back('{idx: ll_regindex, data: ll_wdata, vld: 1'b1});
      starve = nxt;
    end
    #1;
  endtask

  task automatic cyc();
    eval();
    tick();
  endtask

  task automatic set_pipe(input bit en, input logic [4:0] idx, input logic [31:0] d, input bit exc);
    pipe_wr_reg      = en;
    pipe_wr_regindex = idx;
    pipe_wr_wdata    = d;
    pipe_rd_is_x1    = (idx == 5'd1);
    pipe_rd_is_xn    = (idx > 5'd1);
    pipe_exporint    = exc;
  endtask

  task automatic set_ll(input bit v, input logic [4:0] idx, input logic [31:0] d);
    ll_valid    = v;
    ll_regindex = idx;
    ll_wdata    = d;
  endtask

  task automatic idle(input int n);
    set_pipe(1'b0, 5'd0, 32'h0, 1'b0);
    set_ll(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    int  n;
    bit  seen;
    rst = 1'b1;
    chk_rs1idx = 5'd0;
    chk_rs2idx = 5'd0;
    set_pipe(1'b0, 5'd0, 32'h0, 1'b0);
    set_ll(1'b0, 5'd0, 32'h0);
    eval();
    check("rst_ready", ll_ready, 1'b0);
    tick();
    cyc();
    rst = 1'b0;
    eval();
    check("post_rst_ready", ll_ready, 1'b1);
    tick();

    // Single buffered result with an idle pipeline.
    chk_rs1idx = 5'd5;
    set_ll(1'b1, 5'd5, 32'hDEADBEEF);
    cyc();
    set_ll(1'b0, 5'd0, 32'h0);
    eval();
    check("ll_first_wr", wb2regfile_wr_reg, 1'b1);
    check("ll_first_idx", wb2regfile_wr_regindex, 5'd5);
    check("ll_first_data", wb2regfile_wr_wdata, 32'hDEADBEEF);
    check("ll_first_xn", wb2regfile_rd_is_xn, 1'b1);
    check("ll_first_busy", chk_rs1_busy, 1'b1);
    tick();
    eval();
    check("ll_after_busy", chk_rs1_busy, 1'b0);
    tick();

    // Starvation under continuous pipeline writes.
    set_pipe(1'b1, 5'd10, 32'hA0, 1'b0);
    set_ll(1'b1, 5'd7, 32'h77);
    cyc();
    set_ll(1'b0, 5'd0, 32'h0);
    n = 0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      eval();
      if (wb_stall_req) begin
        seen = 1'b1;
        check("stall_wr_idx", wb2regfile_wr_regindex, 5'd7);
      end else n++;
      tick();
    end
    check("stall_seen", seen, 1'b1);
    check("stall_delay", n, STARVE_MAX);
    eval();
    check("stall_len", wb_stall_req, 1'b0);
    check("replay_idx", wb2regfile_wr_regindex, 5'd10);
    tick();

    // Fill the buffer while the pipeline is busy; third offer waits.
    set_ll(1'b1, 5'd3, 32'h33);
    cyc();
    set_ll(1'b1, 5'd4, 32'h44);
    cyc();
    set_ll(1'b1, 5'd6, 32'h66);
    eval();
    check("full_ready", ll_ready, 1'b0);
    tick();
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      eval();
      seen = ll_ready;
      tick();
    end
    check("third_accepted", seen, 1'b1);
    set_ll(1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 12; k++) cyc();
    idle(3);

    // WAW: a younger pipeline write kills the buffered entry.
    chk_rs1idx = 5'd9;
    set_pipe(1'b1, 5'd10, 32'hA1, 1'b0);
    set_ll(1'b1, 5'd9, 32'h11);
    cyc();
    set_ll(1'b0, 5'd0, 32'h0);
    set_pipe(1'b1, 5'd9, 32'h22, 1'b0);
    eval();
    check("waw_pipe_data", wb2regfile_wr_wdata, 32'h22);
    tick();
    set_pipe(1'b0, 5'd0, 32'h0, 1'b0);
    eval();
    check("waw_busy", chk_rs1_busy, 1'b0);
    tick();
    idle(3);

    // Same again with the pipeline write killed by an exception.
    set_pipe(1'b1, 5'd10, 32'hA2, 1'b0);
    set_ll(1'b1, 5'd9, 32'h11);
    cyc();
    set_ll(1'b0, 5'd0, 32'h0);
    set_pipe(1'b1, 5'd9, 32'h22, 1'b1);
    eval();
    check("exc_buf_idx", wb2regfile_wr_regindex, 5'd9);
    check("exc_buf_data", wb2regfile_wr_wdata, 32'h11);
    tick();

    // Exception with an empty buffer writes nothing.
    eval();
    check("exc_empty_wr", wb2regfile_wr_reg, 1'b0);
    tick();
    idle(2);

    // Index 0 is consumed silently.
    chk_rs1idx = 5'd0;
    set_ll(1'b1, 5'd0, 32'h5A5A);
    eval();
    check("x0_ready", ll_ready, 1'b1);
    tick();
    set_ll(1'b0, 5'd0, 32'h0);
    eval();
    check("x0_no_wr", wb2regfile_wr_reg, 1'b0);
    tick();

    // Reset with two entries queued discards them.
    set_pipe(1'b1, 5'd12, 32'hC0, 1'b0);
    set_ll(1'b1, 5'd13, 32'hD1);
    cyc();
    set_ll(1'b1, 5'd14, 32'hD2);
    cyc();
    rst = 1'b1;
    set_ll(1'b0, 5'd0, 32'h0);
    set_pipe(1'b0, 5'd0, 32'h0, 1'b0);
    cyc();
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      eval();
      check("rst_drop_wr", wb2regfile_wr_reg, 1'b0);
      check("rst_drop_ready", ll_ready, 1'b1);
      tick();
    end

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      set_pipe($urandom_range(0, 1) == 1, 5'($urandom_range(0, 4)), $urandom,
               $urandom_range(0, 9) == 0);
      set_ll($urandom_range(0, 2) == 0, 5'($urandom_range(0, 4)), $urandom);
      chk_rs1idx = 5'($urandom_range(0, 4));
      chk_rs2idx = 5'($urandom_range(0, 4));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
